// File: rtl/bcd_seg7_scan.sv
// Purpose : multiplexes NUMCELLS packed-BCD digits onto one common-anode 7-segment display.
// Latency : all outputs registered; the output for counter state (slot, cycle) appears one edge later.
// Backpressure: none; free-running scan, and the digits bus is sampled once per frame.
//
// Ports:
//   clock   system clock
//   rst     synchronous, active-high reset
//   digits  packed BCD, digit i at [4i+3:4i], digit 0 least significant
//   lz_en   1 = suppress leading zeros (sampled live every cycle)
//   seg     segments {g,f,e,d,c,b,a}, active-low
//   dp_n    decimal point, active-low
//   an      anode enables, active-low, an[i] drives digit i
module bcd_seg7_scan #(
    parameter int CLOCKSPEED   = 12000000,
    parameter int NUMCELLS     = 4,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int DP_POS       = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [4*NUMCELLS-1:0] digits,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [NUMCELLS-1:0]   an
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int SLOT = CLOCKSPEED / (REFRESH_HZ * NUMCELLS);

    // Degenerate one-cycle slots or a single digit would give zero-width
    // counters; keep at least one bit so the code stays legal.
    localparam int CW = (SLOT > 1)     ? $clog2(SLOT)     : 1;
    localparam int IW = (NUMCELLS > 1) ? $clog2(NUMCELLS) : 1;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUMCELLS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    // DP_POS == NUMCELLS means "no decimal point anywhere".
    localparam bit            HAS_DP = (DP_POS < NUMCELLS);
    localparam logic [IW-1:0] DP_IDX = HAS_DP ? IW'(DP_POS) : '0;

    // Digits at or below this index are never blanked by zero suppression:
    // the DP digit (so "0.05" keeps its leading zero) or digit 0 otherwise.
    localparam int LZ_FLOOR = HAS_DP ? DP_POS : 0;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // ------------------------------------------------------------------
    // Segment decoder, active-low {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;   // non-BCD code: show a dash
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [CW-1:0]              cnt;
    logic [CW-1:0]              cnt_nxt;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              idx_nxt;
    logic                       run;
    logic                       snap;
    logic [NUMCELLS-1:0][3:0]   shadow;

    logic [NUMCELLS-1:0]        zero_from;
    logic [NUMCELLS-1:0]        lz_elig;
    logic                       suppress;
    logic [3:0]                 cur_dig;
    logic [6:0]                 seg_nxt;
    logic                       dp_n_nxt;
    logic [NUMCELLS-1:0]        an_nxt;

    // Fixed per-digit eligibility for zero suppression.
    for (genvar g = 0; g < NUMCELLS; g++) begin : g_lz_elig
        assign lz_elig[g] = (g > LZ_FLOOR);
    end

    // zero_from[i] = every snapshotted digit from i up to the MSD is zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUMCELLS-1] = (shadow[NUMCELLS-1] == 4'd0);
        for (int i = NUMCELLS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shadow[i] == 4'd0);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        snap      = 1'b0;
        state_nxt = state;
        cur_dig   = shadow[idx];
        suppress  = 1'b0;
        seg_nxt   = SEG_OFF;
        dp_n_nxt  = 1'b1;
        an_nxt    = '1;

        // The first edge out of reset only establishes slot 0 / cycle 0 and
        // takes the first snapshot; counting begins on the edge after.
        if (!run) begin
            cnt_nxt = '0;
            idx_nxt = '0;
            snap    = 1'b1;
        end else if (cnt == SLOT_LAST) begin
            cnt_nxt = '0;
            if (idx == IDX_LAST) begin
                idx_nxt = '0;
                snap    = 1'b1;     // entering digit 0 starts a new frame
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end else begin
            cnt_nxt = cnt + 1'b1;
        end

        // Dead time at the start of every slot hides ghosting from the
        // previous digit's segments while the anodes switch.
        case (state)
            ST_BLANK: if (cnt_nxt >= BLANK_END) state_nxt = ST_DRIVE;
            ST_DRIVE: if (cnt_nxt <  BLANK_END) state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase

        if (state == ST_DRIVE) begin
            an_nxt[idx] = 1'b0;
            suppress    = lz_en && zero_from[idx] && lz_elig[idx];
            seg_nxt     = suppress ? SEG_OFF : bcd_to_seg(cur_dig);
            // The point stays lit even when its digit is a dash.
            dp_n_nxt    = !(HAS_DP && (idx == DP_IDX));
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters, snapshot and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            run    <= 1'b0;
            shadow <= '0;
            seg    <= SEG_OFF;
            dp_n   <= 1'b1;
            an     <= '1;
        end else begin
            cnt  <= cnt_nxt;
            idx  <= idx_nxt;
            run  <= 1'b1;
            if (snap) begin
                shadow <= digits;
            end
            seg  <= seg_nxt;
            dp_n <= dp_n_nxt;
            an   <= an_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Bench for bcd_seg7_scan with SLOT=10, FRAME=40, BLANK_CYCLES=2, DP_POS=2.
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: not applicable; the scan is free-running.
module tb_bcd_seg7_scan;

    logic        clock;
    logic        rst;
    logic [15:0] digits;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;

    bcd_seg7_scan #(
        .CLOCKSPEED  (4000),
        .NUMCELLS    (4),
        .REFRESH_HZ  (100),
        .BLANK_CYCLES(2),
        .DP_POS      (2)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .digits(digits),
        .lz_en (lz_en),
        .seg   (seg),
        .dp_n  (dp_n),
        .an    (an)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    typedef struct {
        logic [15:0]     d;
        logic            lz;
        logic [3:0][6:0] s;     // expected seg per digit index
    } vec_t;

    localparam obs_t BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

    obs_t        exp_q[$];
    obs_t        obs;
    int          checks   = 0;
    int          failures = 0;
    int          k        = -1;     // edges since E0; -1 while in reset
    logic [15:0] m_shadow = '0;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected output after edge E0+kk, given the frame's snapshot and live lz.
    function automatic obs_t model(input int kk, input logic [15:0] sh, input logic lz);
        obs_t o;
        int cc;
        int di;
        logic [3:0] dd;
        o = BLANK;
        if (kk >= 1) begin
            cc = (kk - 1) % 10;
            di = ((kk - 1) / 10) % 4;
            if (cc >= 2) begin
                o.an     = 4'hF;
                o.an[di] = 1'b0;
                dd       = sh[di*4 +: 4];
                o.seg    = (lz && di == 3 && dd == 4'd0) ? 7'h7F : ref_seg(dd);
                o.dp     = (di == 2) ? 1'b0 : 1'b1;
            end
        end
        return o;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s k=%0d: got an=%h seg=%h dp_n=%b, want an=%h seg=%h dp_n=%b",
                     name, k, act.an, act.seg, act.dp, req.an, req.seg, req.dp);
        end
    endtask

    // One clock: queue the expectation, advance, pop and compare.
    task automatic tick();
        obs_t e;
        obs_t got;
        if (rst) begin
            e = BLANK;
            k = -1;
        end else begin
            k = k + 1;
            e = model(k, m_shadow, lz_en);
            if (k % 40 == 0) m_shadow = digits;
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        obs.an  = an;
        obs.seg = seg;
        obs.dp  = dp_n;
        got = exp_q.pop_front();
        check("scoreboard", obs, got);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    vec_t vt[8];
    obs_t want;
    int   cc;
    int   di;
    int   blanks;
    int   lows;

    initial begin
        vt[0] = '{d: 16'h1234, lz: 1'b0, s: {7'h79, 7'h24, 7'h30, 7'h19}};
        vt[1] = '{d: 16'h0005, lz: 1'b1, s: {7'h7F, 7'h40, 7'h40, 7'h12}};
        vt[2] = '{d: 16'h0005, lz: 1'b0, s: {7'h40, 7'h40, 7'h40, 7'h12}};
        vt[3] = '{d: 16'hA0F9, lz: 1'b0, s: {7'h3F, 7'h40, 7'h3F, 7'h10}};
        vt[4] = '{d: 16'h0000, lz: 1'b1, s: {7'h7F, 7'h40, 7'h40, 7'h40}};
        vt[5] = '{d: 16'h0870, lz: 1'b1, s: {7'h7F, 7'h00, 7'h78, 7'h40}};
        vt[6] = '{d: 16'h5678, lz: 1'b1, s: {7'h12, 7'h02, 7'h78, 7'h00}};
        vt[7] = '{d: 16'hBCDE, lz: 1'b1, s: {7'h3F, 7'h3F, 7'h3F, 7'h3F}};

        rst    = 1'b1;
        digits = 16'h0000;
        lz_en  = 1'b0;
        do_reset(3);
        check("reset_state", obs, BLANK);

        // Table vectors: each is snapshotted at a frame boundary and then
        // sampled mid-DRIVE in all four slots of that frame.
        for (int v = 0; v < 8; v++) begin
            digits = vt[v].d;
            lz_en  = vt[v].lz;
            while ((k + 1) % 40 != 0) tick();
            tick();
            repeat (40) begin
                tick();
                cc = (k - 1) % 10;
                di = ((k - 1) / 10) % 4;
                if (cc == 5) begin
                    want.an     = 4'hF;
                    want.an[di] = 1'b0;
                    want.seg    = vt[v].s[di];
                    want.dp     = (di == 2) ? 1'b0 : 1'b1;
                    check($sformatf("vec%0d_idx%0d", v, di), obs, want);
                end
            end
        end

        // Snapshot integrity: digits change at E0+15.
        do_reset(2);
        digits = 16'h1111;
        lz_en  = 1'b0;
        repeat (15) tick();
        digits = 16'h2222;
        repeat (66) begin
            tick();
            cc = (k - 1) % 10;
            di = ((k - 1) / 10) % 4;
            if (cc == 5) begin
                want.an     = 4'hF;
                want.an[di] = 1'b0;
                want.seg    = ((k - 1) / 40 == 0) ? 7'h79 : 7'h24;
                want.dp     = (di == 2) ? 1'b0 : 1'b1;
                check($sformatf("snapshot_k%0d", k), obs, want);
            end
        end

        // Reset asserted mid-DRIVE at E0+25 for 3 cycles.
        do_reset(2);
        digits = 16'h1234;
        repeat (25) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_drive", obs, BLANK);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("restart_idx0", obs, '{an: 4'hE, seg: 7'h19, dp: 1'b1});
        repeat (40) tick();

        // Long run: stopwatch-style counting, changes land mid-frame,
        // lz_en toggles at random points.
        do_reset(2);
        digits = 16'h9985;
        blanks = 0;
        repeat (100 * 40 + 1) begin
            if (k % 40 == 17) digits = bcd_inc(digits);
            if (k % 40 == 30) lz_en = 1'($urandom_range(0, 1));
            tick();
            lows = $countones(~obs.an);
            checks++;
            if (lows > 1) begin
                failures++;
                $display("FAIL an_onehot k=%0d: got an=%h, want at most one low bit", k, obs.an);
            end
            checks++;
            if (obs.dp == 1'b0 && obs.an != 4'hB) begin
                failures++;
                $display("FAIL dp_position k=%0d: got dp_n=0 with an=%h, want an=b", k, obs.an);
            end
            if (k >= 1) begin
                if (obs.an == 4'hF) blanks++;
                if ((k - 1) % 10 == 9) begin
                    checks++;
                    if (blanks != 2) begin
                        failures++;
                        $display("FAIL blank_count k=%0d: got %0d blank cycles, want 2", k, blanks);
                    end
                    blanks = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
